wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Arbitrates the single register-file write port between the in-order writeback path and one
//  long-latency unit (mul/div) result. The writeback path supplies wb_data from the writeback mux.
//  A 1-entry buffer holds a pending long-latency result. An aging counter bounds its wait.
//  The writeback path is stalled when the buffer is granted. Sits between writeback and regfile.
// PARAMETERS
//  XLEN      32  datapath width
//  REG_AW    5   register address width
//  MAX_WAIT  4   cycles a buffered result may lose arbitration before a forced grant (>=1)
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst         in   1       asynchronous, active-high reset
//  pipe_valid  in   1       writeback path has a result this cycle
//  pipe_rd     in   REG_AW  destination register of writeback result
//  pipe_data   in   XLEN    writeback data (wb_data)
//  pipe_stall  out  1       writeback path must hold its result (combinational)
//  ll_valid    in   1       long-latency result offered
//  ll_rd       in   REG_AW  its destination register
//  ll_data     in   XLEN    its data
//  ll_ready    out  1       long-latency result accepted when ll_valid&&ll_ready
//  rf_we       out  1       regfile write enable (registered)
//  rf_waddr    out  REG_AW  regfile write address (registered)
//  rf_wdata    out  XLEN    regfile write data (registered)
// BEHAVIOUR
//  Reset: rf_we=0, rf_waddr=0, rf_wdata=0, buffer empty, wait_cnt=0, state=EMPTY.
//   ll_ready=0 and pipe_stall=0 while rst is high.
//  Definitions: p_req = pipe_valid && pipe_rd!=0; b_req = buffer full (state != EMPTY).
//  Grant, evaluated each cycle:
//   - grant_buf = b_req && (!p_req || state==FORCE || pipe_rd==buf_rd).
//   - Otherwise grant_pipe = p_req.
//   - Same-rd rule: the older buffered result always writes first; the pipe value lands last.
//  pipe_stall = p_req && grant_buf. pipe_valid with rd==0 is consumed, never written, never stalled.
//  Write port: granted source is registered into rf_* on the next edge.
//   Latency is exactly 1 cycle. rf_we=0 in any cycle with no grant.
//  ll_ready = !rst && (state==EMPTY || grant_buf).
//   A new result may enter in the same cycle the old one drains.
//  ll accept with ll_rd==0: handshake completes, data discarded, buffer unchanged.
//  FSM, buffer state:
//   EMPTY:
//     - Accept with rd!=0: load buffer, wait_cnt=0, go to PEND.
//   PEND:
//     - grant_buf: buffer drains. Reload with wait_cnt=0 and stay in PEND if a new result is
//       accepted the same cycle; otherwise go to EMPTY.
//     - Loses arbitration: wait_cnt++. When wait_cnt reaches MAX_WAIT-1, go to FORCE.
//   FORCE:
//     - Buffer always granted this cycle.
//     - Then go to PEND (on reload, wait_cnt=0) or to EMPTY.
//  wait_cnt width is clog2(MAX_WAIT)+1. It saturates and never wraps.
//  Starvation bound: a buffered result is written no later than MAX_WAIT+1 cycles after acceptance.
//  Buffer is never overwritten while full and not draining (ll_ready=0).
//  Reset mid-operation: pending buffer dropped, in-flight rf write suppressed (rf_we=0) immediately.
//  Pipe path has no storage. A stalled pipe result must be re-presented unchanged by upstream.
// TESTING
//  1. Pipe only: pipe_valid, rd=5, data=0xA5A5_0001 -> next cycle rf_we=1, rf_waddr=5,
//     rf_wdata=0xA5A5_0001, pipe_stall=0.
//  2. LL only: ll_valid, rd=7, data=0x1234 with pipe idle -> accepted, rf write x7=0x1234 two
//     cycles after offer.
//  3. Aging: buffer x3 held while pipe writes x1,x2,x4,x5... continuously -> with MAX_WAIT=4,
//     x3 written by cycle 5 and pipe_stall=1 exactly that cycle.
//  4. Same rd: buffer x9=0x11 pending, pipe x9=0x22 arrives -> x9=0x11 written first, then x9=0x22.
//     Final x9=0x22.
//  5. x0 handling: pipe rd=0 and ll rd=0 offered -> no rf_we, no stall, ll_ready handshake completes.
//  6. Async reset asserted with buffer full and pipe_valid -> rf_we=0 and ll_ready=0 immediately.
//     State is EMPTY after release.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order writeback path vs. one buffered long-latency result,
// with an aging counter that forces the buffer through after a bounded number of lost cycles.
module wb_port_arbiter #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pipe_valid,
   input  logic [REG_AW-1:0] pipe_rd,
   input  logic [XLEN-1:0]   pipe_data,
   output logic              pipe_stall,
   input  logic              ll_valid,
   input  logic [REG_AW-1:0] ll_rd,
   input  logic [XLEN-1:0]   ll_data,
   output logic              ll_ready,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [XLEN-1:0]   rf_wdata
);

   localparam int unsigned    CntW    = $clog2(MAX_WAIT) + 1;
   localparam logic [CntW-1:0] CntMax  = '1;
   localparam logic [CntW-1:0] ForceAt = CntW'(MAX_WAIT - 1);

   typedef enum logic [1:0] {StEmpty, StPend, StForce} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [REG_AW-1:0] buf_rd_q, buf_rd_d;
   logic [XLEN-1:0]   buf_data_q, buf_data_d;
   logic              rf_we_q, rf_we_d;
   logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

   logic p_req, b_req, grant_buf, grant_pipe, ll_load;

   always_comb begin
      p_req      = pipe_valid && (pipe_rd != '0);
      b_req      = (state_q != StEmpty);
      // Same-rd conflict goes to the buffer so the older result is overwritten by the newer one.
      grant_buf  = b_req && (!p_req || (state_q == StForce) || (pipe_rd == buf_rd_q));
      grant_pipe = p_req && !grant_buf;
      pipe_stall = !rst && p_req && grant_buf;
      ll_ready   = !rst && ((state_q == StEmpty) || grant_buf);
      // x0 results complete the handshake but never occupy the buffer.
      ll_load    = ll_valid && ll_ready && (ll_rd != '0);
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      buf_rd_d   = buf_rd_q;
      buf_data_d = buf_data_q;
      if (ll_load) begin
         buf_rd_d   = ll_rd;
         buf_data_d = ll_data;
      end
      case (state_q)
         StEmpty: begin
            if (ll_load) begin
               state_d    = StPend;
               wait_cnt_d = '0;
            end
         end
         StPend: begin
            if (grant_buf) begin
               state_d    = ll_load ? StPend : StEmpty;
               wait_cnt_d = '0;
            end else begin
               if (wait_cnt_q != CntMax) begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
               if (wait_cnt_d >= ForceAt) begin
                  state_d = StForce;
               end
            end
         end
         StForce: begin
            state_d    = ll_load ? StPend : StEmpty;
            wait_cnt_d = '0;
         end
         default: begin
            state_d    = StEmpty;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      rf_we_d    = grant_buf || grant_pipe;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (grant_buf) begin
         rf_waddr_d = buf_rd_q;
         rf_wdata_d = buf_data_q;
      end else if (grant_pipe) begin
         rf_waddr_d = pipe_rd;
         rf_wdata_d = pipe_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StEmpty;
         wait_cnt_q <= '0;
         buf_rd_q   <= '0;
         buf_data_q <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         buf_rd_q   <= buf_rd_d;
         buf_data_q <= buf_data_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: pipe-only, LL-only, aging, same-rd, x0 and async reset.
module tb_wb_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_valid;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_data;
   logic        pipe_stall;
   logic        ll_valid;
   logic [4:0]  ll_rd;
   logic [31:0] ll_data;
   logic        ll_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int n_vec = 0;
   int n_err = 0;

   wb_port_arbiter #(.XLEN(32), .REG_AW(5), .MAX_WAIT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .pipe_valid (pipe_valid),
      .pipe_rd    (pipe_rd),
      .pipe_data  (pipe_data),
      .pipe_stall (pipe_stall),
      .ll_valid   (ll_valid),
      .ll_rd      (ll_rd),
      .ll_data    (ll_data),
      .ll_ready   (ll_ready),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
      pipe_valid = pv;
      pipe_rd    = prd;
      pipe_data  = pd;
      ll_valid   = lv;
      ll_rd      = lrd;
      ll_data    = ld;
   endtask

   logic [4:0] age_rd [6];

   initial begin
      rst = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      tick();
      check_eq("rst_we", {31'b0, rf_we}, 32'd0);
      check_eq("rst_waddr", {27'b0, rf_waddr}, 32'd0);
      check_eq("rst_wdata", rf_wdata, 32'd0);
      check_eq("rst_ll_ready", {31'b0, ll_ready}, 32'd0);
      check_eq("rst_stall", {31'b0, pipe_stall}, 32'd0);
      rst = 1'b0;
      #1;
      check_eq("idle_ll_ready", {31'b0, ll_ready}, 32'd1);

      // 1. pipe only
      drive(1'b1, 5'd5, 32'hA5A5_0001, 1'b0, 5'd0, 32'h0);
      #1 check_eq("t1_stall", {31'b0, pipe_stall}, 32'd0);
      tick();
      check_eq("t1_we", {31'b0, rf_we}, 32'd1);
      check_eq("t1_waddr", {27'b0, rf_waddr}, 32'd5);
      check_eq("t1_wdata", rf_wdata, 32'hA5A5_0001);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      tick();
      check_eq("t1_idle_we", {31'b0, rf_we}, 32'd0);

      // 2. LL only: write lands two edges after the offer
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234);
      #1 check_eq("t2_ready", {31'b0, ll_ready}, 32'd1);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      check_eq("t2_we_early", {31'b0, rf_we}, 32'd0);
      tick();
      check_eq("t2_we", {31'b0, rf_we}, 32'd1);
      check_eq("t2_waddr", {27'b0, rf_waddr}, 32'd7);
      check_eq("t2_wdata", rf_wdata, 32'h1234);
      tick();

      // 3. aging: x3 buffered at cycle 0, pipe busy every cycle; forced at cycle 4
      age_rd[0] = 5'd1; age_rd[1] = 5'd2; age_rd[2] = 5'd4;
      age_rd[3] = 5'd5; age_rd[4] = 5'd6; age_rd[5] = 5'd6;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, age_rd[i], {24'h0, 3'b0, age_rd[i]} << 8, i == 0, 5'd3, 32'h33);
         #1;
         check_eq($sformatf("t3_stall_c%0d", i), {31'b0, pipe_stall}, (i == 4) ? 32'd1 : 32'd0);
         if (i == 1) check_eq("t3_ready_pend", {31'b0, ll_ready}, 32'd0);
         if (i == 4) check_eq("t3_ready_force", {31'b0, ll_ready}, 32'd1);
         tick();
         check_eq($sformatf("t3_we_c%0d", i), {31'b0, rf_we}, 32'd1);
         check_eq($sformatf("t3_waddr_c%0d", i), {27'b0, rf_waddr},
                  (i == 4) ? 32'd3 : {27'b0, age_rd[i]});
         check_eq($sformatf("t3_wdata_c%0d", i), rf_wdata,
                  (i == 4) ? 32'h33 : ({27'b0, age_rd[i]} << 8));
      end

      // 4. same rd: buffered x9=0x11 must write before pipe x9=0x22
      drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd9, 32'h11);
      tick();
      drive(1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'h0);
      #1 check_eq("t4_stall", {31'b0, pipe_stall}, 32'd1);
      tick();
      check_eq("t4_first_waddr", {27'b0, rf_waddr}, 32'd9);
      check_eq("t4_first_wdata", rf_wdata, 32'h11);
      #1 check_eq("t4_stall2", {31'b0, pipe_stall}, 32'd0);
      tick();
      check_eq("t4_last_we", {31'b0, rf_we}, 32'd1);
      check_eq("t4_last_wdata", rf_wdata, 32'h22);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      tick();

      // 5. x0 on both sides
      drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
      #1;
      check_eq("t5_stall", {31'b0, pipe_stall}, 32'd0);
      check_eq("t5_ready", {31'b0, ll_ready}, 32'd1);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      check_eq("t5_we", {31'b0, rf_we}, 32'd0);
      check_eq("t5_ready_after", {31'b0, ll_ready}, 32'd1);
      tick();
      check_eq("t5_no_buf_write", {31'b0, rf_we}, 32'd0);

      // 6. async reset with buffer full and a write in flight
      drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd10, 32'hAA);
      tick();
      drive(1'b1, 5'd2, 32'h200, 1'b0, 5'd0, 32'h0);
      tick();
      check_eq("t6_we_inflight", {31'b0, rf_we}, 32'd1);
      rst = 1'b1;
      #1;
      check_eq("t6_rst_we", {31'b0, rf_we}, 32'd0);
      check_eq("t6_rst_ready", {31'b0, ll_ready}, 32'd0);
      check_eq("t6_rst_stall", {31'b0, pipe_stall}, 32'd0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      rst = 1'b0;
      #1 check_eq("t6_ready_empty", {31'b0, ll_ready}, 32'd1);
      tick();
      check_eq("t6_buf_dropped", {31'b0, rf_we}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
